// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the regfile single write port.
// Round-robin grants one of NREQ requesters per cycle, registers the winning
// write toward the regfile, and keeps a per-register busy scoreboard that the
// issue stage reads to stall on pending writes.
module regfile_wb_arbiter #(
  parameter int DATA_W    = 64,
  parameter int REG_COUNT = 32,
  parameter int NREQ      = 3,
  localparam int AW       = $clog2(REG_COUNT),
  localparam int IW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*AW-1:0]     req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic [NREQ-1:0]        req_ready,
  output logic                   wr_en,
  output logic [AW-1:0]          wr1_addr,
  output logic [DATA_W-1:0]      wr1_data,
  output logic [IW-1:0]          grant_id,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_addr,
  input  logic [AW-1:0]          rd1_addr,
  input  logic [AW-1:0]          rd2_addr,
  output logic                   rd1_busy,
  output logic                   rd2_busy
);

  logic [IW-1:0]        ptr;
  logic [IW-1:0]        grant_idx;
  logic                 grant_valid;
  logic [REG_COUNT-1:0] busy;

  // Round-robin search from ptr upward with wrap; first valid requester wins.
  // Depends only on req_valid and ptr, never on the payload.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    req_ready   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_valid && req_valid[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(idx);
      end
    end
    if (rst) begin
      grant_valid = 1'b0;
    end else if (grant_valid) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // Register the granted write and advance the pointer past the winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      wr_en    <= 1'b0;
      wr1_addr <= '0;
      wr1_data <= '0;
      grant_id <= '0;
    end else if (grant_valid) begin
      ptr      <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      wr_en    <= 1'b1;
      wr1_addr <= req_addr[int'(grant_idx)*AW +: AW];
      wr1_data <= req_data[int'(grant_idx)*DATA_W +: DATA_W];
      grant_id <= grant_idx;
    end else begin
      wr_en <= 1'b0;
    end
  end

  // Busy scoreboard: commit clears, issue sets; a same-address collision keeps it set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the scoreboard is a flop vector, not a RAM, so it can and must be
      // reset; a stale busy bit after reset would stall issue forever.
      busy <= '0;
    end else begin
      // NOTE: with non-blocking assignments the later statement wins, which is
      // exactly the set-over-clear priority wanted here.
      if (wr_en)  busy[wr1_addr] <= 1'b0;
      if (iss_en) busy[iss_addr] <= 1'b1;
    end
  end

  // Busy lookups read state only; the committing write is not bypassed.
  always_comb begin
    rd1_busy = 1'b0;
    rd2_busy = 1'b0;
    if (!rst) begin
      rd1_busy = busy[rd1_addr];
      rd2_busy = busy[rd2_addr];
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: table-driven arbitration vectors,
// a write scoreboard queue checked on the falling edge, and hand-written
// sequences for the scoreboard, collision and mid-stream reset cases.
module tb_regfile_wb_arbiter;

  localparam int DATA_W = 64;
  localparam int AW     = 5;
  localparam int IW     = 2;
  localparam int NREQ   = 3;

  logic                   clk;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*AW-1:0]     req_addr;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   wr_en;
  logic [AW-1:0]          wr1_addr;
  logic [DATA_W-1:0]      wr1_data;
  logic [IW-1:0]          grant_id;
  logic                   iss_en;
  logic [AW-1:0]          iss_addr;
  logic [AW-1:0]          rd1_addr;
  logic [AW-1:0]          rd2_addr;
  logic                   rd1_busy;
  logic                   rd2_busy;

  regfile_wb_arbiter #(.DATA_W(DATA_W), .REG_COUNT(32), .NREQ(NREQ)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .wr_en(wr_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .grant_id(grant_id),
    .iss_en(iss_en), .iss_addr(iss_addr),
    .rd1_addr(rd1_addr), .rd2_addr(rd2_addr),
    .rd1_busy(rd1_busy), .rd2_busy(rd2_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data;
    logic [IW-1:0]     id;
  } wr_t;

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [NREQ-1:0] ready;
  } vec_t;

  wr_t               exp_q[$];
  logic [AW-1:0]     pay_addr[NREQ];
  logic [DATA_W-1:0] pay_data[NREQ];
  int                n_checks = 0;
  int                n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_payload();
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW]         = pay_addr[i];
      req_data[i*DATA_W +: DATA_W] = pay_data[i];
    end
  endtask

  task automatic refresh(input int i);
    pay_addr[i] = AW'($urandom_range(10, 31));
    pay_data[i] = {$urandom, $urandom};
  endtask

  task automatic push(input int i);
    wr_t w;
    w.addr = pay_addr[i];
    w.data = pay_data[i];
    w.id   = IW'(i);
    exp_q.push_back(w);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single requester i presents (a, d); expects an immediate grant. Returns
  // one edge later, inside the cycle where wr_en should be high.
  task automatic request(input int i, input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
    pay_addr[i] = a;
    pay_data[i] = d;
    drive_payload();
    req_valid = NREQ'(1 << i);
    #1;
    check("req_ready_single", req_ready, 64'(1 << i));
    push(i);
    step();
    req_valid = '0;
  endtask

  // Write monitor: every registered write must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(wr1_addr), 64'hFFFF);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr1_addr", 64'(wr1_addr), 64'(w.addr));
        check("wr1_data", wr1_data, w.data);
        check("grant_id", 64'(grant_id), 64'(w.id));
      end
    end
  end

  initial begin
    vec_t tbl[15];
    logic prev_any;
    tbl[0]  = '{3'b111, 3'b001};
    tbl[1]  = '{3'b111, 3'b010};
    tbl[2]  = '{3'b111, 3'b100};
    tbl[3]  = '{3'b111, 3'b001};
    tbl[4]  = '{3'b111, 3'b010};
    tbl[5]  = '{3'b111, 3'b100};
    tbl[6]  = '{3'b000, 3'b000};
    tbl[7]  = '{3'b010, 3'b010};
    tbl[8]  = '{3'b011, 3'b001};
    tbl[9]  = '{3'b010, 3'b010};
    tbl[10] = '{3'b110, 3'b100};
    tbl[11] = '{3'b010, 3'b010};
    tbl[12] = '{3'b101, 3'b100};
    tbl[13] = '{3'b001, 3'b001};
    tbl[14] = '{3'b000, 3'b000};

    for (int i = 0; i < NREQ; i++) refresh(i);
    rst       = 1'b1;
    req_valid = 3'b111;
    drive_payload();
    iss_en    = 1'b0;
    iss_addr  = '0;
    rd1_addr  = '0;
    rd2_addr  = '0;

    // Reset state with all requesters valid.
    step();
    step();
    check("rst_req_ready", req_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_rd1_busy", rd1_busy, 0);
    check("rst_rd2_busy", rd2_busy, 0);
    check("rst_wr1_addr", wr1_addr, 0);
    check("rst_wr1_data", wr1_data, 0);
    check("rst_grant_id", grant_id, 0);
    rst = 1'b0;

    // Arbitration table; rows 0-5 are the continuous fairness run.
    prev_any = 1'b0;
    for (int r = 0; r < 15; r++) begin
      check("wr_en_follows_grant", wr_en, prev_any);
      req_valid = tbl[r].valid;
      drive_payload();
      #1;
      check("req_ready_tbl", req_ready, tbl[r].ready);
      for (int i = 0; i < NREQ; i++) begin
        if (tbl[r].ready[i]) begin
          push(i);
          refresh(i);
        end
      end
      prev_any = |tbl[r].ready;
      step();
    end
    req_valid = '0;
    check("wr_en_after_tbl", wr_en, prev_any);

    // Single write (pointer now at 1).
    request(1, 5'd5, 64'hDEADBEEFCAFEBABE);
    check("single_wr_en", wr_en, 1);
    check("single_wr1_addr", wr1_addr, 5);
    check("single_wr1_data", wr1_data, 64'hDEADBEEFCAFEBABE);
    check("single_grant_id", grant_id, 1);
    step();
    check("single_wr_en_drop", wr_en, 0);

    // Scoreboard set then clear by a commit from requester 2.
    iss_en   = 1'b1;
    iss_addr = 5'd7;
    step();
    iss_en   = 1'b0;
    rd1_addr = 5'd7;
    rd2_addr = 5'd8;
    #1;
    check("sb_busy7_set", rd1_busy, 1);
    check("sb_busy8_clear", rd2_busy, 0);
    request(2, 5'd7, 64'h0123456789ABCDEF);
    check("sb_commit_wr_en", wr_en, 1);
    check("sb_busy_during_commit", rd1_busy, 1);
    step();
    check("sb_busy_after_commit", rd1_busy, 0);
    check("sb_wr_en_drop", wr_en, 0);

    // Set/clear collision on register 3 (pointer now at 0).
    request(0, 5'd3, 64'h3333_0000_3333_0000);
    iss_en   = 1'b1;
    iss_addr = 5'd3;
    rd2_addr = 5'd3;
    #1;
    check("coll_wr1_addr", wr1_addr, 3);
    check("coll_busy_before", rd2_busy, 0);
    step();
    iss_en = 1'b0;
    check("coll_busy_after", rd2_busy, 1);
    step();
    check("coll_busy_holds", rd2_busy, 1);

    // Asynchronous reset while a write to register 9 is pending (pointer at 1).
    iss_en   = 1'b1;
    iss_addr = 5'd9;
    step();
    iss_en = 1'b0;
    request(1, 5'd9, 64'h9999_9999_9999_9999);
    rd1_addr = 5'd9;
    #1;
    check("mid_wr_en_before", wr_en, 1);
    check("mid_busy9_before", rd1_busy, 1);
    req_valid = 3'b111;
    drive_payload();
    #1;
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("mid_wr_en_async", wr_en, 0);
    check("mid_busy9_async", rd1_busy, 0);
    check("mid_ready_in_rst", req_ready, 0);
    step();
    check("mid_no_write_edge", wr_en, 0);
    rst = 1'b0;
    #1;
    check("mid_busy9_after", rd1_busy, 0);
    check("mid_busy3_after", rd2_busy, 0);
    check("mid_ptr_reset", req_ready, 3'b001);
    push(0);
    step();
    req_valid = '0;
    check("mid_regrant_wr_en", wr_en, 1);
    step();
    check("queue_drained", 64'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
